// File: rtl/usb_cmd_pkg.sv
// Shared definitions for the USB RX command decoder: FSM states, command
// word field positions and fixed response header/data values.
package usb_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE,
        FETCH,
        LATCH,
        EXEC,
        READ_WAIT,
        RESP
    } state_t;

    localparam int RW_BIT   = 39;
    localparam int ADDR_MSB = 38;
    localparam int ADDR_LSB = 32;

    localparam logic [6:0]  PING_ADDR = 7'h7F;
    localparam logic [7:0]  ERR_HDR   = 8'hFE;
    localparam logic [31:0] ERR_DATA  = 32'hDEAD_DEAD;
    localparam logic [7:0]  VER_HDR   = 8'hFF;

endpackage

// File: rtl/usb_rx_command_decoder.sv
// Host command decoder between the USB 3 RX FIFO and the TX control FIFO.
// Pops one 40-bit command at a time and turns it into a register write,
// a register read (with timeout) or a ping, pushing responses to the TX FIFO.
// Optional build macro USB_RX_CMD_WRITE_ACK_EN: non-ping writes are echoed
// back to the TX FIFO as an acknowledgement.
module usb_rx_command_decoder
    import usb_cmd_pkg::*;
#(
    parameter int          TIMEOUT_CYC  = 1024,
    parameter logic [31:0] VERSION_WORD = 32'h0001_0000
) (
    input  logic        Clock,
    input  logic        Reset,
    input  logic [39:0] RX_Fifo_Data,
    input  logic        RX_Fifo_Empty,
    output logic        RX_Fifo_RE,
    output logic [6:0]  Reg_Addr,
    output logic [31:0] Reg_WData,
    output logic        Reg_WE,
    output logic        Reg_RE,
    input  logic [31:0] Reg_RData,
    input  logic        Reg_RValid,
    output logic [39:0] TX_Fifo_Data,
    output logic        TX_Fifo_WE,
    input  logic        TX_Fifo_Full,
    output logic        Busy
);

    localparam int CNT_W = (TIMEOUT_CYC > 1) ? $clog2(TIMEOUT_CYC) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYC - 1);

    state_t            state_reg, state_next;
    logic [39:0]       cmd_reg, cmd_next;
    logic [39:0]       resp_reg, resp_next;
    logic [CNT_W-1:0]  cnt_reg, cnt_next;
    logic [6:0]        addr_reg, addr_next;
    logic [31:0]       wdata_reg, wdata_next;

    logic              cmd_is_read;
    logic              cmd_is_ping;
    logic [6:0]        cmd_addr;

    assign cmd_is_read = cmd_reg[RW_BIT];
    assign cmd_addr    = cmd_reg[ADDR_MSB:ADDR_LSB];
    assign cmd_is_ping = (cmd_addr == PING_ADDR);

    // The response word is registered, so it stays stable through any backpressure.
    assign TX_Fifo_Data = resp_reg;
    assign TX_Fifo_WE   = (state_reg == RESP) && !TX_Fifo_Full;
    assign Busy         = (state_reg != IDLE);

    // State and datapath registers; reset discards any command already popped.
    always_ff @(posedge Clock) begin
        if (Reset) begin
            state_reg <= IDLE;
            cmd_reg   <= '0;
            resp_reg  <= '0;
            cnt_reg   <= '0;
            addr_reg  <= '0;
            wdata_reg <= '0;
        end else begin
            state_reg <= state_next;
            cmd_reg   <= cmd_next;
            resp_reg  <= resp_next;
            cnt_reg   <= cnt_next;
            addr_reg  <= addr_next;
            wdata_reg <= wdata_next;
        end
    end

    // Next-state and strobe decode; register bus address/data hold between strobes.
    always_comb begin
        state_next = state_reg;
        cmd_next   = cmd_reg;
        resp_next  = resp_reg;
        cnt_next   = cnt_reg;
        addr_next  = addr_reg;
        wdata_next = wdata_reg;
        RX_Fifo_RE = 1'b0;
        Reg_WE     = 1'b0;
        Reg_RE     = 1'b0;
        Reg_Addr   = addr_reg;
        Reg_WData  = wdata_reg;

        case (state_reg)
            IDLE: begin
                if (!RX_Fifo_Empty) begin
                    state_next = FETCH;
                end
            end
            FETCH: begin
                // Single pop; data appears next cycle (non-show-ahead FIFO).
                RX_Fifo_RE = 1'b1;
                state_next = LATCH;
            end
            LATCH: begin
                cmd_next   = RX_Fifo_Data;
                state_next = EXEC;
            end
            EXEC: begin
                if (cmd_is_ping) begin
                    resp_next  = cmd_is_read ? {VER_HDR, VERSION_WORD} : cmd_reg;
                    state_next = RESP;
                end else if (cmd_is_read) begin
                    Reg_RE     = 1'b1;
                    Reg_Addr   = cmd_addr;
                    addr_next  = cmd_addr;
                    cnt_next   = '0;
                    state_next = READ_WAIT;
                end else begin
                    Reg_WE     = 1'b1;
                    Reg_Addr   = cmd_addr;
                    Reg_WData  = cmd_reg[31:0];
                    addr_next  = cmd_addr;
                    wdata_next = cmd_reg[31:0];
`ifdef USB_RX_CMD_WRITE_ACK_EN
                    resp_next  = cmd_reg;
                    state_next = RESP;
`else
                    state_next = IDLE;
`endif
                end
            end
            READ_WAIT: begin
                // Valid data wins over a timeout landing in the same cycle.
                if (Reg_RValid) begin
                    resp_next  = {cmd_reg[39:32], Reg_RData};
                    state_next = RESP;
                end else if (cnt_reg == CNT_LAST) begin
                    resp_next  = {ERR_HDR, ERR_DATA};
                    state_next = RESP;
                end else begin
                    cnt_next = cnt_reg + 1'b1;
                end
            end
            RESP: begin
                if (!TX_Fifo_Full) begin
                    state_next = IDLE;
                end
            end
            default: begin
                state_next = IDLE;
            end
        endcase
    end

endmodule
